// File: rtl/ipsxe_floating_point_rom_c_arb_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ipsxe_floating_point_rom_c_arb_if
//  Purpose  : Request/grant, ROM-port and response bundle for the shared
//             constant-ROM round-robin arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface ipsxe_floating_point_rom_c_arb_if #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2,
    parameter int FW       = 32
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [4*NUM_REQ-1:0] req_addr;
    logic [NUM_REQ-1:0]   req_ready;
    logic [3:0]           rom_rd_addr;
    logic [FW-1:0]        rom_dout;
    logic                 rsp_valid;
    logic [ID_WIDTH-1:0]  rsp_id;
    logic [FW-1:0]        rsp_data;
    logic                 rsp_addr_err;
    logic                 busy;

    // Arbiter side: takes requests and ROM data, returns grants and responses
    modport slave (
        input  req_valid, req_addr, rom_dout,
        output req_ready, rom_rd_addr, rsp_valid, rsp_id, rsp_data,
               rsp_addr_err, busy
    );

    // Environment side: requesters plus the ROM instance
    modport master (
        output req_valid, req_addr, rom_dout,
        input  req_ready, rom_rd_addr, rsp_valid, rsp_id, rsp_data,
               rsp_addr_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/ipsxe_floating_point_rom_c_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ipsxe_floating_point_rom_c_arb
//  Purpose  : Round-robin arbiter sharing one 1-cycle registered constant ROM
//             among NUM_REQ FP requesters; results return tagged with the
//             requester ID two cycles after acceptance.
//  Revision : 1.0 - initial release
// ============================================================================
module ipsxe_floating_point_rom_c_arb #(
    parameter int NUM_REQ   = 4,
    parameter int ID_WIDTH  = 2,
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    ipsxe_floating_point_rom_c_arb_if.slave bus
);
    localparam int FW = 1 + EXP_WIDTH + MAN_WIDTH;
    localparam logic [ID_WIDTH-1:0] c_LAST_ID = ID_WIDTH'(NUM_REQ - 1);

    // Round-robin pointer and pipeline stages
    logic [ID_WIDTH-1:0] r_rr_ptr;
    logic [3:0]          r_rom_rd_addr;
    logic                r_s1_valid;
    logic [ID_WIDTH-1:0] r_s1_id;
    logic                r_s1_err;
    logic                r_rsp_valid;
    logic [ID_WIDTH-1:0] r_rsp_id;
    logic                r_rsp_err;

    // Arbitration results
    logic [NUM_REQ-1:0]  w_grant;
    logic                w_found;
    logic [ID_WIDTH-1:0] w_win_id;
    logic [3:0]          w_win_addr;
    logic                w_accept;
    logic [ID_WIDTH-1:0] w_next_ptr;
    int                  w_idx;

    // Search req_valid from r_rr_ptr upward with wrap; first set bit wins
    always_comb begin
        w_grant    = '0;
        w_found    = 1'b0;
        w_win_id   = '0;
        w_win_addr = '0;
        w_idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found        = 1'b1;
                w_grant[w_idx] = 1'b1;
                w_win_id       = ID_WIDTH'(w_idx);
                w_win_addr     = bus.req_addr[4*w_idx +: 4];
            end
        end
    end

    // No grants are offered while reset is asserted
    assign w_accept      = w_found & rst_n;
    assign bus.req_ready = w_grant & {NUM_REQ{rst_n}};

    // Pointer moves one past the winner, wrapping at NUM_REQ (not 2**ID_WIDTH)
    assign w_next_ptr = (w_win_id == c_LAST_ID) ? '0 : w_win_id + 1'b1;

    // Accept stage: advance pointer, issue ROM address, capture tag/error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr      <= '0;
            r_rom_rd_addr <= '0;
            r_s1_valid    <= 1'b0;
            r_s1_id       <= '0;
            r_s1_err      <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_rr_ptr      <= w_next_ptr;
                r_rom_rd_addr <= w_win_addr;
                r_s1_id       <= w_win_id;
                r_s1_err      <= (w_win_addr > 4'd3);
            end
        end
    end

    // Response stage: aligned with the ROM's registered output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= r_s1_valid;
            r_rsp_id    <= r_s1_id;
            r_rsp_err   <= r_s1_err;
        end
    end

    assign bus.rom_rd_addr  = r_rom_rd_addr;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_id       = r_rsp_id;
    assign bus.rsp_addr_err = r_rsp_err;
    assign bus.rsp_data     = r_rsp_valid ? bus.rom_dout : {FW{1'b0}};
    assign bus.busy         = r_s1_valid | r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_ipsxe_floating_point_rom_c_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ipsxe_floating_point_rom_c_arb
//  Purpose  : Directed self-checking bench for the constant-ROM arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ipsxe_floating_point_rom_c_arb;
    localparam int NUM_REQ  = 4;
    localparam int ID_WIDTH = 2;
    localparam int FW       = 32;
    // Expected winners for the mixed-contention sequence
    localparam int GID [9]  = '{3, 0, 3, 0, 1, 2, 3, 0, 1};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ipsxe_floating_point_rom_c_arb_if #(
        .NUM_REQ (NUM_REQ),
        .ID_WIDTH(ID_WIDTH),
        .FW      (FW)
    ) u_if ();

    ipsxe_floating_point_rom_c_arb #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH),
        .EXP_WIDTH(8),
        .MAN_WIDTH(23)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (u_if.slave)
    );

    function automatic logic [31:0] romv(input logic [3:0] a);
        case (a)
            4'd0:    romv = 32'h40C00000;
            4'd1:    romv = 32'h7F800000;
            4'd2:    romv = 32'h00000000;
            4'd3:    romv = 32'h7FC00000;
            default: romv = 32'h00000000;
        endcase
    endfunction

    // Shared ROM: 1-cycle registered read
    always @(posedge clk) u_if.rom_dout <= romv(u_if.rom_rd_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        u_if.req_valid = '0;
        u_if.req_addr  = '0;
        rst_n          = 1'b0;
        repeat (3) tick();

        // Reset state, including no grant while reset is held
        u_if.req_valid = 4'b1111;
        #1;
        chk("rst_ready",    32'(u_if.req_ready),    32'h0);
        chk("rst_rsp_val",  32'(u_if.rsp_valid),    32'h0);
        chk("rst_rsp_id",   32'(u_if.rsp_id),       32'h0);
        chk("rst_rsp_err",  32'(u_if.rsp_addr_err), 32'h0);
        chk("rst_busy",     32'(u_if.busy),         32'h0);
        chk("rst_rd_addr",  32'(u_if.rom_rd_addr),  32'h0);
        chk("rst_rsp_data", u_if.rsp_data,          32'h0);
        u_if.req_valid = '0;
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Single request from requester 2, address 0
        u_if.req_valid = 4'b0100;
        u_if.req_addr  = 16'h0000;
        #1;
        chk("t1_ready", 32'(u_if.req_ready), 32'h4);
        tick();
        u_if.req_valid = '0;
        #1;
        chk("t1_rd_addr", 32'(u_if.rom_rd_addr), 32'h0);
        chk("t1_busy",    32'(u_if.busy),        32'h1);
        chk("t1_rsp_v0",  32'(u_if.rsp_valid),   32'h0);
        tick();
        chk("t1_rsp_v",   32'(u_if.rsp_valid),    32'h1);
        chk("t1_rsp_id",  32'(u_if.rsp_id),       32'h2);
        chk("t1_rsp_d",   u_if.rsp_data,          32'h40C00000);
        chk("t1_rsp_err", 32'(u_if.rsp_addr_err), 32'h0);
        tick();

        // Requesters 0 and 3 (pointer at 3), then all four: 3,0,3 then 0,1,2,3,0,1
        u_if.req_addr = 16'h3210;
        for (int k = 0; k < 11; k++) begin
            if (k < 3)      u_if.req_valid = 4'b1001;
            else if (k < 9) u_if.req_valid = 4'b1111;
            else            u_if.req_valid = 4'b0000;
            #1;
            if (k < 9) begin
                chk($sformatf("rr_ready_%0d", k), 32'(u_if.req_ready), 32'(1 << GID[k]));
            end
            if (k >= 2) begin
                chk($sformatf("rr_rsp_v_%0d", k),  32'(u_if.rsp_valid), 32'h1);
                chk($sformatf("rr_rsp_id_%0d", k), 32'(u_if.rsp_id),    32'(GID[k-2]));
                chk($sformatf("rr_rsp_d_%0d", k),  u_if.rsp_data,       romv(4'(GID[k-2])));
            end
            tick();
        end
        chk("rr_idle_v",    32'(u_if.rsp_valid), 32'h0);
        chk("rr_idle_busy", 32'(u_if.busy),      32'h0);
        chk("rr_idle_d",    u_if.rsp_data,       32'h0);

        // Requester 1: out-of-range address 9, then address 0
        u_if.req_valid = 4'b0010;
        u_if.req_addr  = 16'h0090;
        #1;
        chk("err_ready0", 32'(u_if.req_ready), 32'h2);
        tick();
        u_if.req_addr = 16'h0000;
        #1;
        chk("err_ready1",  32'(u_if.req_ready),   32'h2);
        chk("err_rd_addr", 32'(u_if.rom_rd_addr), 32'h9);
        tick();
        u_if.req_valid = '0;
        #1;
        chk("err_rsp_v",   32'(u_if.rsp_valid),    32'h1);
        chk("err_rsp_id",  32'(u_if.rsp_id),       32'h1);
        chk("err_rsp_d",   u_if.rsp_data,          32'h0);
        chk("err_rsp_err", 32'(u_if.rsp_addr_err), 32'h1);
        tick();
        chk("ok_rsp_v",   32'(u_if.rsp_valid),    32'h1);
        chk("ok_rsp_id",  32'(u_if.rsp_id),       32'h1);
        chk("ok_rsp_d",   u_if.rsp_data,          32'h40C00000);
        chk("ok_rsp_err", 32'(u_if.rsp_addr_err), 32'h0);
        tick();

        // Requester 0 back-to-back: addresses 1, 2, 3
        u_if.req_valid = 4'b0001;
        u_if.req_addr  = 16'h0001;
        #1;
        chk("b2b_ready", 32'(u_if.req_ready), 32'h1);
        tick();
        u_if.req_addr = 16'h0002;
        tick();
        u_if.req_addr = 16'h0003;
        #1;
        chk("b2b_d1",   u_if.rsp_data,       32'h7F800000);
        chk("b2b_id1",  32'(u_if.rsp_id),    32'h0);
        tick();
        u_if.req_valid = '0;
        #1;
        chk("b2b_v2",   32'(u_if.rsp_valid),    32'h1);
        chk("b2b_d2",   u_if.rsp_data,          32'h00000000);
        chk("b2b_err2", 32'(u_if.rsp_addr_err), 32'h0);
        tick();
        chk("b2b_d3",   u_if.rsp_data,       32'h7FC00000);
        chk("b2b_id3",  32'(u_if.rsp_id),    32'h0);
        tick();
        chk("b2b_idle", 32'(u_if.rsp_valid), 32'h0);

        // Reset while two accepted requests are in flight (pointer at 1)
        u_if.req_valid = 4'b1100;
        u_if.req_addr  = 16'h3200;
        #1;
        chk("rf_ready0", 32'(u_if.req_ready), 32'h4);
        tick();
        chk("rf_ready1", 32'(u_if.req_ready), 32'h8);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("rf_rsp_v",   32'(u_if.rsp_valid),   32'h0);
        chk("rf_busy",    32'(u_if.busy),        32'h0);
        chk("rf_ready",   32'(u_if.req_ready),   32'h0);
        chk("rf_rd_addr", 32'(u_if.rom_rd_addr), 32'h0);
        u_if.req_valid = 4'b1001;
        u_if.req_addr  = 16'h3000;
        tick();
        chk("rf_rsp_v2",  32'(u_if.rsp_valid), 32'h0);
        chk("rf_busy2",   32'(u_if.busy),      32'h0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rf_first_gnt", 32'(u_if.req_ready), 32'h1);
        tick();
        chk("rf_second_gnt", 32'(u_if.req_ready), 32'h8);
        tick();
        u_if.req_valid = '0;
        #1;
        chk("rf_rsp_id0", 32'(u_if.rsp_id), 32'h0);
        chk("rf_rsp_d0",  u_if.rsp_data,    32'h40C00000);
        tick();
        chk("rf_rsp_id3", 32'(u_if.rsp_id), 32'h3);
        chk("rf_rsp_d3",  u_if.rsp_data,    32'h7FC00000);
        tick();
        chk("rf_idle", 32'(u_if.rsp_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
